// File: rtl/overlay_pkg.sv
// Shared types and helpers for the rectangle overlay on the AXI4-Stream video path.
package overlay_pkg;

    localparam int OVL_COMP_W  = 10;
    localparam int OVL_COORD_W = 12;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_FILL   = 2'd1,
        MODE_BORDER = 2'd2,
        MODE_BLEND  = 2'd3
    } mode_e;

    // c0 occupies the lowest bits of a pixel slot, c2 the highest.
    typedef struct packed {
        logic [OVL_COMP_W-1:0] c2;
        logic [OVL_COMP_W-1:0] c1;
        logic [OVL_COMP_W-1:0] c0;
    } pixel_t;

    typedef struct packed {
        mode_e                  mode;
        logic [OVL_COORD_W-1:0] x0;
        logic [OVL_COORD_W-1:0] x1;
        logic [OVL_COORD_W-1:0] y0;
        logic [OVL_COORD_W-1:0] y1;
        pixel_t                 color;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{
        mode:  MODE_BYPASS,
        x0:    {OVL_COORD_W{1'b0}},
        x1:    {OVL_COORD_W{1'b0}},
        y0:    {OVL_COORD_W{1'b0}},
        y1:    {OVL_COORD_W{1'b0}},
        color: {(3*OVL_COMP_W){1'b0}}
    };

    // Coordinates stick at all-ones instead of wrapping back into the rectangle.
    function automatic logic [OVL_COORD_W-1:0] sat_add(input logic [OVL_COORD_W-1:0] a,
                                                       input logic [OVL_COORD_W-1:0] b);
        logic [OVL_COORD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[OVL_COORD_W] ? {OVL_COORD_W{1'b1}} : sum[OVL_COORD_W-1:0];
    endfunction

    function automatic logic [OVL_COMP_W-1:0] blend_comp(input logic [OVL_COMP_W-1:0] a,
                                                         input logic [OVL_COMP_W-1:0] b);
        logic [OVL_COMP_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[OVL_COMP_W:1];
    endfunction

endpackage

// File: rtl/axis_rect_overlay_if.sv
// Video stream bundle: upstream input side, downstream output side.
interface axis_rect_overlay_if #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0] s_axis_video_tdata_in;
    logic              s_axis_video_tvalid_in;
    logic              s_axis_video_tready_out;
    logic              s_axis_video_tuser_in;
    logic              s_axis_video_tlast_in;
    logic [DATA_W-1:0] s_axis_video_tdata_out;
    logic              s_axis_video_tvalid_out;
    logic              s_axis_video_tready_in;
    logic              s_axis_video_tuser_out;
    logic              s_axis_video_tlast_out;

    modport slave (
        input  s_axis_video_tdata_in, s_axis_video_tvalid_in, s_axis_video_tuser_in,
               s_axis_video_tlast_in, s_axis_video_tready_in,
        output s_axis_video_tready_out, s_axis_video_tdata_out, s_axis_video_tvalid_out,
               s_axis_video_tuser_out, s_axis_video_tlast_out
    );

    modport master (
        output s_axis_video_tdata_in, s_axis_video_tvalid_in, s_axis_video_tuser_in,
               s_axis_video_tlast_in, s_axis_video_tready_in,
        input  s_axis_video_tready_out, s_axis_video_tdata_out, s_axis_video_tvalid_out,
               s_axis_video_tuser_out, s_axis_video_tlast_out
    );
endinterface

// File: rtl/overlay_pixel.sv
// Combinational per-pixel overlay decision: bypass, fill, 1-pixel border or 50% blend.
module overlay_pixel
    import overlay_pkg::*;
(
    input  pixel_t                 pix_in,
    input  logic [OVL_COORD_W-1:0] px,
    input  logic [OVL_COORD_W-1:0] py,
    input  cfg_t                   cfg,
    output pixel_t                 pix_out
);

    logic in_rect_s;
    logic on_edge_s;

    // An inverted bound (x0>x1 or y0>y1) makes in_rect_s false everywhere.
    assign in_rect_s = (px >= cfg.x0) && (px <= cfg.x1) && (py >= cfg.y0) && (py <= cfg.y1);
    assign on_edge_s = (px == cfg.x0) || (px == cfg.x1) || (py == cfg.y0) || (py == cfg.y1);

    // Select the replacement pixel for the configured mode.
    always_comb begin
        pix_out = pix_in;
        case (cfg.mode)
            MODE_BYPASS: pix_out = pix_in;
            MODE_FILL: begin
                if (in_rect_s) pix_out = cfg.color;
                else           pix_out = pix_in;
            end
            MODE_BORDER: begin
                if (in_rect_s && on_edge_s) pix_out = cfg.color;
                else                        pix_out = pix_in;
            end
            MODE_BLEND: begin
                if (in_rect_s) begin
                    pix_out.c0 = blend_comp(pix_in.c0, cfg.color.c0);
                    pix_out.c1 = blend_comp(pix_in.c1, cfg.color.c1);
                    pix_out.c2 = blend_comp(pix_in.c2, cfg.color.c2);
                end else begin
                    pix_out = pix_in;
                end
            end
            default: pix_out = pix_in;
        endcase
    end

endmodule

// File: rtl/axis_rect_overlay.sv
// Two-stage AXI4-Stream overlay: tracks pixel coordinates and paints a programmable
// rectangle; configuration is captured on each start-of-frame beat.
module axis_rect_overlay
    import overlay_pkg::*;
#(
    parameter int PPC     = 2,
    parameter int COMP_W  = OVL_COMP_W,
    parameter int PIX_W   = 32,
    parameter int DATA_W  = PPC * PIX_W,
    parameter int COORD_W = OVL_COORD_W
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  aclken,
    axis_rect_overlay_if.slave    vid,
    input  logic [1:0]            cfg_mode,
    input  logic [COORD_W-1:0]    cfg_x0,
    input  logic [COORD_W-1:0]    cfg_x1,
    input  logic [COORD_W-1:0]    cfg_y0,
    input  logic [COORD_W-1:0]    cfg_y1,
    input  logic [3*COMP_W-1:0]   cfg_color,
    output logic [15:0]           frame_cnt
);

    logic               adv_s;
    logic               accept_s;
    cfg_t               cfg_live_s;
    cfg_t               cfg_sh_r;
    logic [COORD_W-1:0] bx_s, by_s, nx_s, ny_s;
    logic [COORD_W-1:0] x_r, y_r;
    logic               v1_r, v2_r;
    logic [DATA_W-1:0]  d1_r, d2_r;
    logic               u1_r, u2_r, l1_r, l2_r;
    logic [COORD_W-1:0] sx_r, sy_r;
    logic [DATA_W-1:0]  mod_data_s;

    // Stage 2 only blocks when it holds a beat the downstream has not taken.
    assign adv_s    = aclken & (~v2_r | vid.s_axis_video_tready_in);
    assign accept_s = vid.s_axis_video_tvalid_in & adv_s;

    assign vid.s_axis_video_tready_out = adv_s;
    assign vid.s_axis_video_tvalid_out = v2_r;
    assign vid.s_axis_video_tdata_out  = d2_r;
    assign vid.s_axis_video_tuser_out  = u2_r;
    assign vid.s_axis_video_tlast_out  = l2_r;

    // Live configuration view, captured into the shadow on a start-of-frame beat.
    always_comb begin
        cfg_live_s       = CFG_DEFAULT;
        cfg_live_s.mode  = mode_e'(cfg_mode);
        cfg_live_s.x0    = cfg_x0;
        cfg_live_s.x1    = cfg_x1;
        cfg_live_s.y0    = cfg_y0;
        cfg_live_s.y1    = cfg_y1;
        cfg_live_s.color = pixel_t'(cfg_color);
    end

    // Coordinate of the incoming beat and of the beat after it; tuser applies before tlast.
    always_comb begin
        if (vid.s_axis_video_tuser_in) begin
            bx_s = {COORD_W{1'b0}};
            by_s = {COORD_W{1'b0}};
        end else begin
            bx_s = x_r;
            by_s = y_r;
        end
        if (vid.s_axis_video_tlast_in) begin
            nx_s = {COORD_W{1'b0}};
            ny_s = sat_add(by_s, COORD_W'(1));
        end else begin
            nx_s = sat_add(bx_s, COORD_W'(PPC));
            ny_s = by_s;
        end
    end

    // Coordinate tracking, config shadow and frame counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x_r       <= {COORD_W{1'b0}};
            y_r       <= {COORD_W{1'b0}};
            cfg_sh_r  <= CFG_DEFAULT;
            frame_cnt <= 16'd0;
        end else if (accept_s) begin
            x_r <= nx_s;
            y_r <= ny_s;
            if (vid.s_axis_video_tuser_in) begin
                cfg_sh_r  <= cfg_live_s;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Stage 1 captures the beat with its coordinate; the shadow it was tagged with stays
    // in cfg_sh_r until this beat moves on, since a newer tuser can only land on that edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1_r <= 1'b0;
            d1_r <= {DATA_W{1'b0}};
            u1_r <= 1'b0;
            l1_r <= 1'b0;
            sx_r <= {COORD_W{1'b0}};
            sy_r <= {COORD_W{1'b0}};
        end else if (adv_s) begin
            v1_r <= accept_s;
            if (accept_s) begin
                d1_r <= vid.s_axis_video_tdata_in;
                u1_r <= vid.s_axis_video_tuser_in;
                l1_r <= vid.s_axis_video_tlast_in;
                sx_r <= bx_s;
                sy_r <= by_s;
            end
        end
    end

    for (genvar i = 0; i < PPC; i++) begin : g_pix
        pixel_t             pin_s;
        pixel_t             pout_s;
        logic [COORD_W-1:0] px_s;

        assign px_s  = sat_add(sx_r, COORD_W'(i));
        assign pin_s = pixel_t'(d1_r[i*PIX_W +: 3*COMP_W]);

        overlay_pixel u_pixel (
            .pix_in  (pin_s),
            .px      (px_s),
            .py      (sy_r),
            .cfg     (cfg_sh_r),
            .pix_out (pout_s)
        );

        assign mod_data_s[i*PIX_W +: 3*COMP_W] = pout_s;
        if (PIX_W > 3*COMP_W) begin : g_pad
            assign mod_data_s[i*PIX_W+3*COMP_W +: PIX_W-3*COMP_W] =
                d1_r[i*PIX_W+3*COMP_W +: PIX_W-3*COMP_W];
        end
    end

    // Stage 2 holds the modified beat until the downstream takes it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v2_r <= 1'b0;
            d2_r <= {DATA_W{1'b0}};
            u2_r <= 1'b0;
            l2_r <= 1'b0;
        end else if (adv_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                d2_r <= mod_data_s;
                u2_r <= u1_r;
                l2_r <= l1_r;
            end
        end
    end

endmodule

// File: tb/tb_axis_rect_overlay.sv
// Scoreboard bench for axis_rect_overlay: a reference model queues the expected beat on
// every accepted input and each output handshake is compared against the queue head.
`timescale 1ns/1ps
module tb_axis_rect_overlay;

    localparam int PPC = 2, COMP_W = 10, PIX_W = 32, DATA_W = 64, COORD_W = 12;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        aclken = 1'b1;
    logic [1:0]  cfg_mode;
    logic [11:0] cfg_x0, cfg_x1, cfg_y0, cfg_y1;
    logic [29:0] cfg_color;
    logic [15:0] frame_cnt;

    axis_rect_overlay_if #(.DATA_W(DATA_W)) vid ();

    axis_rect_overlay #(
        .PPC(PPC), .COMP_W(COMP_W), .PIX_W(PIX_W), .DATA_W(DATA_W), .COORD_W(COORD_W)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .aclken    (aclken),
        .vid       (vid),
        .cfg_mode  (cfg_mode),
        .cfg_x0    (cfg_x0),
        .cfg_x1    (cfg_x1),
        .cfg_y0    (cfg_y0),
        .cfg_y1    (cfg_y1),
        .cfg_color (cfg_color),
        .frame_cnt (frame_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        logic        user;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_total = 0;
    int          n_bad = 0;
    int          ncyc = 0;
    bit          bp_en = 0, ck_en = 0, gaps_en = 0, lat_chk = 0, pix_mode = 0;
    // reference model state
    int          mx = 0, my = 0, s_mode = 0, s_x0 = 0, s_x1 = 0, s_y0 = 0, s_y1 = 0;
    logic [29:0] s_color = '0;
    logic [15:0] m_fcnt = 16'd0;
    int          bx_m, by_m;
    exp_t        e_in, e_out;
    logic [63:0] d_m;
    bit          prev_stall = 0;
    logic [66:0] prev_word;

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_pix(input logic [31:0] p, input int px, input int py);
        logic [31:0] r;
        int          a, c;
        bit          ins, edg;
        r   = p;
        ins = (px >= s_x0) && (px <= s_x1) && (py >= s_y0) && (py <= s_y1);
        edg = (px == s_x0) || (px == s_x1) || (py == s_y0) || (py == s_y1);
        if ((s_mode == 1 && ins) || (s_mode == 2 && ins && edg)) r[29:0] = s_color;
        if (s_mode == 3 && ins) begin
            for (int k = 0; k < 3; k++) begin
                a = int'(p[k*10 +: 10]);
                c = int'(s_color[k*10 +: 10]);
                r[k*10 +: 10] = 10'((a + c) / 2);
            end
        end
        return r;
    endfunction

    // Downstream ready and clock-enable stimulus, changed just after each rising edge.
    always @(posedge aclk) begin
        #1;
        vid.s_axis_video_tready_in = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
        aclken = ck_en ? ($urandom_range(0, 99) >= 10) : 1'b1;
    end

    // Monitor on the falling edge: hold check, output compare, then model the input beat.
    always @(negedge aclk) begin
        ncyc++;
        if (!aresetn) begin
            sb_q.delete();
            mx = 0; my = 0; s_mode = 0; s_x0 = 0; s_x1 = 0; s_y0 = 0; s_y1 = 0;
            s_color = '0; m_fcnt = 16'd0; prev_stall = 0;
        end else begin
            if (prev_stall)
                check_val("stall_hold", {vid.s_axis_video_tvalid_out, vid.s_axis_video_tuser_out,
                          vid.s_axis_video_tlast_out, vid.s_axis_video_tdata_out}, prev_word);
            if (vid.s_axis_video_tvalid_out && vid.s_axis_video_tready_in && aclken) begin
                if (sb_q.size() == 0) begin
                    check_val("extra_beat", 72'd1, 72'd0);
                end else begin
                    e_out = sb_q.pop_front();
                    check_val("tdata", vid.s_axis_video_tdata_out, e_out.data);
                    check_val("tuser", vid.s_axis_video_tuser_out, e_out.user);
                    check_val("tlast", vid.s_axis_video_tlast_out, e_out.last);
                    if (lat_chk) check_val("latency", ncyc - e_out.cyc, 72'd2);
                end
            end
            prev_stall = vid.s_axis_video_tvalid_out && !(vid.s_axis_video_tready_in && aclken);
            prev_word  = {vid.s_axis_video_tvalid_out, vid.s_axis_video_tuser_out,
                          vid.s_axis_video_tlast_out, vid.s_axis_video_tdata_out};
            if (vid.s_axis_video_tvalid_in && vid.s_axis_video_tready_out) begin
                d_m = vid.s_axis_video_tdata_in;
                if (vid.s_axis_video_tuser_in) begin
                    s_mode = int'(cfg_mode); s_x0 = int'(cfg_x0); s_x1 = int'(cfg_x1);
                    s_y0 = int'(cfg_y0); s_y1 = int'(cfg_y1); s_color = cfg_color;
                    m_fcnt = m_fcnt + 16'd1;
                    bx_m = 0; by_m = 0;
                end else begin
                    bx_m = mx; by_m = my;
                end
                for (int i = 0; i < PPC; i++)
                    e_in.data[i*32 +: 32] = exp_pix(d_m[i*32 +: 32],
                                                    (bx_m + i > 4095) ? 4095 : bx_m + i, by_m);
                e_in.user = vid.s_axis_video_tuser_in;
                e_in.last = vid.s_axis_video_tlast_in;
                e_in.cyc  = ncyc;
                sb_q.push_back(e_in);
                if (vid.s_axis_video_tlast_in) begin
                    mx = 0;
                    my = (by_m < 4095) ? by_m + 1 : 4095;
                end else begin
                    mx = (bx_m + PPC < 4095) ? bx_m + PPC : 4095;
                    my = by_m;
                end
            end
        end
    end

    task automatic set_cfg(input logic [1:0] m, input int x0, x1, y0, y1, input logic [29:0] col);
        cfg_mode = m;
        cfg_x0 = 12'(x0); cfg_x1 = 12'(x1); cfg_y0 = 12'(y0); cfg_y1 = 12'(y1);
        cfg_color = col;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic u, input logic l);
        int  to;
        bit  acc;
        if (gaps_en) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
        vid.s_axis_video_tdata_in  = d;
        vid.s_axis_video_tuser_in  = u;
        vid.s_axis_video_tlast_in  = l;
        vid.s_axis_video_tvalid_in = 1'b1;
        to = 0;
        acc = 0;
        while (!acc && to < 1000) begin
            @(negedge aclk);
            acc = vid.s_axis_video_tready_out;
            @(posedge aclk); #1;
            to++;
        end
        if (!acc) check_val("accept_timeout", 72'd0, 72'd1);
        vid.s_axis_video_tvalid_in = 1'b0;
        vid.s_axis_video_tuser_in  = 1'b0;
        vid.s_axis_video_tlast_in  = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int max_beats, input int chg_line);
        int          nb;
        logic [31:0] r;
        logic [63:0] d;
        nb = 0;
        for (int y = 0; y < h; y++) begin
            for (int b = 0; b < w / PPC; b++) begin
                if (max_beats >= 0 && nb >= max_beats) return;
                if (y == chg_line && b == 0) cfg_mode = 2'd0;
                for (int i = 0; i < PPC; i++) begin
                    r = $urandom;
                    d[i*32 +: 32] = pix_mode ? {r[31:30], 10'd600, 10'd1, 10'd1023} : r;
                end
                send_beat(d, (y == 0 && b == 0), (b == w / PPC - 1));
                nb++;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 2000) begin
            @(posedge aclk);
            t++;
        end
        if (sb_q.size() != 0) check_val("drain_timeout", 72'(sb_q.size()), 72'd0);
        repeat (3) @(posedge aclk);
        #1;
        check_val("frame_cnt", frame_cnt, m_fcnt);
    endtask

    task automatic reset_check(input string tag);
        repeat (3) begin
            @(negedge aclk);
            check_val({tag, "_tvalid"}, vid.s_axis_video_tvalid_out, 72'd0);
            check_val({tag, "_tdata"}, vid.s_axis_video_tdata_out, 72'd0);
            check_val({tag, "_tuser"}, vid.s_axis_video_tuser_out, 72'd0);
            check_val({tag, "_tlast"}, vid.s_axis_video_tlast_out, 72'd0);
            check_val({tag, "_fcnt"}, frame_cnt, 72'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vid.s_axis_video_tdata_in  = '0;
        vid.s_axis_video_tvalid_in = 1'b0;
        vid.s_axis_video_tuser_in  = 1'b0;
        vid.s_axis_video_tlast_in  = 1'b0;
        set_cfg(2'd0, 0, 0, 0, 0, 30'd0);
        aresetn = 1'b0;
        reset_check("reset");
        check_val("reset_tready", vid.s_axis_video_tready_out, 72'd1);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // fill, no stalls, latency checked
        set_cfg(2'd1, 2, 5, 1, 2, {10'd512, 10'd0, 10'd1023});
        lat_chk = 1;
        send_frame(8, 4, -1, -1);
        drain();
        lat_chk = 0;

        // border on the same rectangle
        set_cfg(2'd2, 2, 5, 1, 2, {10'd512, 10'd0, 10'd1023});
        send_frame(8, 4, -1, -1);
        drain();

        // blend: (1023,1023)->1023, (1,0)->0, (600,401)->500
        pix_mode = 1;
        set_cfg(2'd3, 2, 5, 1, 2, {10'd401, 10'd0, 10'd1023});
        send_frame(8, 4, -1, -1);
        drain();
        pix_mode = 0;

        // backpressure, input gaps and clock-enable pauses
        bp_en = 1; gaps_en = 1; ck_en = 1;
        set_cfg(2'd2, 0, 15, 0, 5, 30'h2AA_5555);
        send_frame(16, 6, -1, -1);
        set_cfg(2'd3, 3, 9, 2, 4, 30'h155_AAAA);
        send_frame(16, 6, -1, -1);
        drain();
        bp_en = 0; gaps_en = 0; ck_en = 0;
        repeat (2) @(posedge aclk);
        #1;

        // reset in the middle of line 2 with beats still in flight
        set_cfg(2'd1, 2, 5, 1, 2, 30'h3FF_FFFF);
        send_frame(8, 4, 10, -1);
        aresetn = 1'b0;
        reset_check("midrst");
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // config shadowing: mode drops to bypass at line 2, applies from next frame only
        set_cfg(2'd1, 2, 5, 1, 2, {10'd512, 10'd0, 10'd1023});
        send_frame(8, 4, -1, 2);
        drain();
        send_frame(8, 4, -1, -1);
        drain();
        check_val("fcnt_shadow", frame_cnt, 72'd2);

        // inverted x bounds: empty rectangle
        set_cfg(2'd1, 5, 2, 1, 2, 30'h3FF_FFFF);
        send_frame(8, 4, -1, -1);
        drain();
        check_val("fcnt_final", frame_cnt, 72'd3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
